// File: rtl/ppc_fetch_queue.sv
// ppc_fetch_queue: decoupled instruction-fetch front end.
// Issues doubleword requests, splits each returned word into one or two
// 32-bit instructions and buffers them with their PCs for decode.
// A redirect flushes the queue and retires in-flight responses as stale.
// PC and data buses use big-endian bit numbering (bit 0 is the MSB).
module ppc_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [0:63] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [0:60] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [0:63] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [0:31] inst,
    output logic [0:63] inst_pc,
    input  logic        redirect_valid,
    input  logic [0:63] redirect_pc
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUT + 1);
    localparam int SW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef struct packed {
        logic [0:31] inst;
        logic [0:63] pc;
    } qEntry_t;

    typedef struct packed {
        logic        startSlot;
        logic [0:63] pc;
    } slotEntry_t;

    // Fetch PC and request bookkeeping
    logic [0:63]    fpc;
    logic [OCW-1:0] outCnt;
    logic [OCW-1:0] outCntNext;
    logic [OCW-1:0] dropCnt;

    // Per-request start slot / base PC, popped in response order
    slotEntry_t     slotMem [MAX_OUT];
    logic [SW-1:0]  slotWr;
    logic [SW-1:0]  slotRd;
    slotEntry_t     rspHead;

    // Instruction queue; pointers carry a wrap bit so count falls out of them
    qEntry_t        qMem [DEPTH];
    logic [PW-1:0]  rdPtr;
    logic [PW-1:0]  wrPtr;
    logic [CW-1:0]  count;
    logic [AW-1:0]  rdIdx;
    logic [AW-1:0]  wrIdx0;
    logic [AW-1:0]  wrIdx1;

    logic           reqFire;
    logic           rspFire;
    logic           deqFire;
    logic           rspLive;
    logic [1:0]     enqN;
    qEntry_t        entry0;
    qEntry_t        entry1;
    int             room;

    // Low redirect bits are word-alignment noise and are dropped on purpose
    logic           unusedRedirectLsbs;
    assign unusedRedirectLsbs = ^redirect_pc[62:63];

    function automatic logic [SW-1:0] slotInc(input logic [SW-1:0] p);
        return (p == SW'(MAX_OUT - 1)) ? '0 : p + SW'(1);
    endfunction

    assign count   = CW'(wrPtr - rdPtr);
    assign rdIdx   = rdPtr[AW-1:0];
    assign wrIdx0  = wrPtr[AW-1:0];
    assign wrIdx1  = wrPtr[AW-1:0] + AW'(1);
    assign rspHead = slotMem[slotRd];

    assign reqFire = mem_req_valid & mem_req_ready;
    assign rspFire = mem_rsp_valid;
    assign deqFire = inst_valid & inst_ready;

    // A response only lands in the queue if it is neither stale nor racing a redirect
    assign rspLive = rspFire & (dropCnt == '0) & ~redirect_valid;

    assign outCntNext = outCnt + OCW'(reqFire) - OCW'(rspFire);

    assign mem_req_addr = fpc[0:60];
    assign inst_valid   = (count != '0);
    assign inst         = qMem[rdIdx].inst;
    assign inst_pc      = qMem[rdIdx].pc;

    // Free queue space after every live request claims two entries
    always_comb begin
        room = DEPTH - int'(count) - 2 * (int'(outCnt) - int'(dropCnt));
    end

    // Request only while both the outstanding limit and the reservation allow it
    always_comb begin
        mem_req_valid = rst_n & (outCnt < OCW'(MAX_OUT)) & (room >= 2);
    end

    // Split the returned doubleword into queue entries by start slot
    always_comb begin
        enqN        = 2'd0;
        entry0.inst = rspHead.startSlot ? mem_rsp_data[32:63] : mem_rsp_data[0:31];
        entry0.pc   = rspHead.pc;
        entry1.inst = mem_rsp_data[32:63];
        entry1.pc   = rspHead.pc + 64'd4;
        if (rspLive) begin
            enqN = rspHead.startSlot ? 2'd1 : 2'd2;
        end
    end

    // Fetch PC, outstanding/stale counters and slot FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc     <= RESET_PC;
            outCnt  <= '0;
            dropCnt <= '0;
            slotWr  <= '0;
            slotRd  <= '0;
        end else begin
            outCnt <= outCntNext;
            if (reqFire) slotWr <= slotInc(slotWr);
            if (rspFire) slotRd <= slotInc(slotRd);
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path
                fpc     <= {redirect_pc[0:61], 2'b00};
                dropCnt <= outCntNext;
            end else begin
                if (reqFire) fpc <= fpc + (fpc[61] ? 64'd4 : 64'd8);
                if (rspFire && dropCnt != '0) dropCnt <= dropCnt - OCW'(1);
            end
        end
    end

    // Record start slot and base PC of each accepted request
    always_ff @(posedge clk) begin
        if (reqFire) begin
            slotMem[slotWr] <= '{startSlot: fpc[61], pc: fpc};
        end
    end

    // Queue pointers; a redirect empties the queue after honouring any dequeue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
        end else if (redirect_valid) begin
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            rdPtr <= rdPtr + PW'(deqFire);
            wrPtr <= wrPtr + PW'(enqN);
        end
    end

    // Queue storage writes, one or two entries per live response
    always_ff @(posedge clk) begin
        if (enqN != 2'd0) qMem[wrIdx0] <= entry0;
        if (enqN == 2'd2) qMem[wrIdx1] <= entry1;
    end

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// Directed bench for ppc_fetch_queue: in-order memory model plus an
// instruction scoreboard filled as responses are delivered.
module tb_ppc_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [0:60] mem_req_addr;
    logic        mem_rsp_valid;
    logic [0:63] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [0:31] inst;
    logic [0:63] inst_pc;
    logic        redirect_valid;
    logic [0:63] redirect_pc;

    typedef struct {
        logic [60:0] addr;
        logic [63:0] pc;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    req_t        inflight[$];
    exp_t        expQ[$];
    logic [63:0] mFpc;
    bit          rspEn;
    bit          hit;
    int          nChecks = 0;
    int          nFail   = 0;

    ppc_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memWord(input logic [60:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return {lo ^ 32'hA500_0000, ~lo};
    endfunction

    function automatic int liveReqs();
        int n = 0;
        foreach (inflight[i]) if (!inflight[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic driveRsp();
        if (rspEn && rst_n && inflight.size() != 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memWord(inflight[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    endtask

    // One clock: check outputs at negedge, then update model and memory after posedge
    task automatic tick();
        bit          reqF, rspF, deqF, redir, expRv;
        logic [63:0] rpc;
        logic [63:0] w;
        req_t        rec;
        exp_t        e;
        @(negedge clk);
        reqF  = mem_req_valid && mem_req_ready;
        rspF  = mem_rsp_valid;
        deqF  = inst_valid && inst_ready;
        redir = redirect_valid;
        rpc   = redirect_pc;
        expRv = rst_n && (inflight.size() < MAX_OUT) &&
                (DEPTH - expQ.size() - 2 * liveReqs() >= 2);
        check("inst_valid", inst_valid, expQ.size() != 0);
        check("mem_req_valid", mem_req_valid, expRv);
        if (mem_req_valid) check("mem_req_addr", mem_req_addr, {3'b0, mFpc[63:3]});
        if (deqF) begin
            check("deq_nonempty", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check("inst", inst, e.inst);
                check("inst_pc", inst_pc, e.pc);
            end
        end
        @(posedge clk);
        #1;
        if (reqF) begin
            inflight.push_back('{addr: mFpc[63:3], pc: mFpc, stale: 1'b0});
            mFpc = mFpc + (mFpc[2] ? 64'd4 : 64'd8);
        end
        if (rspF && inflight.size() != 0) begin
            rec = inflight.pop_front();
            if (!rec.stale && !redir) begin
                w = memWord(rec.addr);
                if (!rec.pc[2]) begin
                    expQ.push_back('{inst: w[63:32], pc: rec.pc});
                    expQ.push_back('{inst: w[31:0], pc: rec.pc + 64'd4});
                end else begin
                    expQ.push_back('{inst: w[31:0], pc: rec.pc});
                end
            end
        end
        if (redir) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            expQ.delete();
            mFpc = {rpc[63:2], 2'b00};
        end
        driveRsp();
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_req_ready  = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rspEn          = 1'b1;
        mFpc           = RESET_PC;

        // Reset state
        repeat (2) tick();
        check("rst_inst_valid", inst_valid, 0);
        check("rst_req_valid", mem_req_valid, 0);
        #2 rst_n = 1'b1;

        // Streaming fetch from RESET_PC
        repeat (16) tick();

        // Redirect to 0x104 with two requests outstanding
        rspEn = 1'b0;
        driveRsp();
        for (int i = 0; i < 10 && inflight.size() != 2; i++) tick();
        check("two_outstanding", inflight.size(), 2);
        check("req_blocked_at_max", mem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h104;
        tick();
        redirect_valid = 1'b0;
        rspEn          = 1'b1;
        driveRsp();
        repeat (12) tick();

        // Decode stall: queue fills, requests stop, release drains in order
        inst_ready = 1'b0;
        repeat (20) tick();
        check("stall_inst_valid", inst_valid, 1);
        check("stall_req_valid", mem_req_valid, 0);
        inst_ready = 1'b1;
        repeat (16) tick();

        // Memory stall with a redirect in the middle of it
        mem_req_ready = 1'b0;
        repeat (5) tick();
        check("stall_addr", mem_req_addr, {3'b0, mFpc[63:3]});
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        tick();
        redirect_valid = 1'b0;
        check("stall_redir_addr", mem_req_addr, 64'h400);
        repeat (2) tick();
        mem_req_ready = 1'b1;
        repeat (10) tick();

        // Redirect coinciding with a live response and a dequeue
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (mem_rsp_valid && inst_valid && inflight.size() != 0 && !inflight[0].stale)
                hit = 1'b1;
        end
        check("redir_rsp_deq_found", hit, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        tick();
        redirect_valid = 1'b0;
        check("flush_empty", inst_valid, 0);
        repeat (10) tick();

        // PC wrap and a misaligned redirect that starts in slot 1
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        repeat (12) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h207;
        tick();
        redirect_valid = 1'b0;
        repeat (10) tick();

        // Randomised handshakes and redirects
        for (int i = 0; i < 300; i++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            rspEn          = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = {$urandom, $urandom};
            driveRsp();
            tick();
        end
        inst_ready     = 1'b1;
        mem_req_ready  = 1'b1;
        rspEn          = 1'b1;
        redirect_valid = 1'b0;
        driveRsp();
        repeat (10) tick();

        // Asynchronous reset mid-burst
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_inst_valid", inst_valid, 0);
        check("async_rst_req_valid", mem_req_valid, 0);
        inflight.delete();
        expQ.delete();
        mFpc = RESET_PC;
        driveRsp();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
